// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction memory fetch block.
// Fault indices address bits of rsp_fault; NOP_DEFAULT is addi x0,x0,0.
package imem_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 register array, one synchronous write port and one registered read port.
// The read register holds its value until the next read and resets to RST_DATA.
module imem_array #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = $clog2(DEPTH),
    parameter logic [31:0] RST_DATA = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage has no reset; the owning FSM clears it row by row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= RST_DATA;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Handshaked instruction memory for the fetch stage: self-clears to NOP, accepts program loads,
// serves one-cycle registered fetches. Define IMEM_FAULT_EN to flag misaligned/out-of-range PCs.
//
//   state | meaning
//   CLEAR | writing NOP_INST into row clr_cnt each cycle; no loads or fetches accepted
//   RUN   | loads and fetches served, loads take priority over fetches
module imem_fetch
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_INST = NOP_DEFAULT,
    localparam int         ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic [31:0]       rsp_pc,
    output logic [1:0]        rsp_fault,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              init_done
);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic [1:0]        rsp_fault_q, rsp_fault_d;
    logic [1:0]        fault_d;
    logic              running, accept;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [31:0]       arr_wdata, arr_rdata;

    assign running   = (state_q == RUN) && !reset;
    assign ld_ready  = running;
    assign req_ready = running && !ld_valid && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        fault_d = '0;
`ifdef IMEM_FAULT_EN
        fault_d[FAULT_MISALIGN] = |req_pc[1:0];
        fault_d[FAULT_RANGE]    = |req_pc[31:ADDR_W+2];
`endif
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_fault_d = rsp_fault_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_pc_d    = req_pc;
            rsp_fault_d = fault_d;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            rsp_fault_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Clear owns the write port until RUN; afterwards the load port does.
    assign arr_we    = !reset && ((state_q == CLEAR) || ld_valid);
    assign arr_waddr = (state_q == CLEAR) ? clr_cnt_q : ld_addr;
    assign arr_wdata = (state_q == CLEAR) ? NOP_INST : ld_data;

    imem_array #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RST_DATA (NOP_INST)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (accept),
        .raddr (req_pc[ADDR_W+1:2]),
        .rdata (arr_rdata)
    );

`ifdef IMEM_FAULT_EN
    assign rsp_inst = (rsp_fault_q != '0) ? NOP_INST : arr_rdata;
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc[31:ADDR_W+2], req_pc[1:0]};
    assign rsp_inst = arr_rdata;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_pc    = rsp_pc_q;
    assign rsp_fault = rsp_fault_q;
    assign init_done = init_done_q;

endmodule
